// File: rtl/output_neuron_if.sv
// Event bus between the neuron-unit fabric, the WTA arbiter and one output
// neuron.
//
// Handshake: there is no ready signal anywhere on this bus. Every signal is a
// single-cycle pulse. valid_li qualifies won_lost: won_lost is meaningful only
// in a cycle where valid_li is high. The neuron samples valid_li/won_lost in
// every ARB cycle, including the cycle in which it raises start_li.
//
// Signals:
//   TU_incre, isor_0_start, isor_1_start, li, spike_ip_nub, valid_li,
//   won_lost                            : into the neuron
//   spike_op_nu, start_li, valid_nu     : out of the neuron
interface output_neuron_if;
  logic TU_incre;
  logic isor_0_start;
  logic isor_1_start;
  logic li;
  logic spike_ip_nub;
  logic valid_li;
  logic won_lost;
  logic spike_op_nu;
  logic start_li;
  logic valid_nu;

  modport master (
    output TU_incre, isor_0_start, isor_1_start, li, spike_ip_nub, valid_li,
           won_lost,
    input  spike_op_nu, start_li, valid_nu
  );

  modport slave (
    input  TU_incre, isor_0_start, isor_1_start, li, spike_ip_nub, valid_li,
           won_lost,
    output spike_op_nu, start_li, valid_nu
  );
endinterface

// File: rtl/output_neuron.sv
// Leaky integrate-and-fire output-layer neuron.
//
// Integrates input spikes into an unsigned membrane potential, leaks on each
// TU boundary and takes lateral inhibition. In training mode a threshold
// crossing is arbitrated through an external WTA block; in inference mode it
// fires directly. All state and outputs are registered.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   nif       : event bus (slave side), see output_neuron_if
//   dbg_state : current FSM state (0 IDLE, 1 INTEG, 2 ARB, 3 REFRAC)
//   dbg_v     : current membrane potential
module output_neuron #(
  parameter int MEMB_W    = 16,
  parameter int V_TH      = 100,
  parameter int INC       = 10,
  parameter int LEAK      = 1,
  parameter int INH       = 50,
  parameter int REFRAC_TU = 2,
  parameter int T_WIN     = 16
) (
  input  logic              clk,
  input  logic              rst,
  output_neuron_if.slave    nif,
  output logic [1:0]        dbg_state,
  output logic [MEMB_W-1:0] dbg_v
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INTEG  = 2'd1,
    ARB    = 2'd2,
    REFRAC = 2'd3
  } state_t;

  localparam int SW = MEMB_W + 2;
  localparam int TW = $clog2(T_WIN + 1);
  localparam int RW = $clog2(REFRAC_TU + 1);

  localparam logic signed [SW-1:0] INC_S  = SW'(INC);
  localparam logic signed [SW-1:0] LEAK_S = SW'(LEAK);
  localparam logic signed [SW-1:0] INH_S  = SW'(INH);
  localparam logic signed [SW-1:0] ZERO_S = '0;
  localparam logic signed [SW-1:0] MAX_S  = $signed({2'b00, {MEMB_W{1'b1}}});

  state_t            state_q, state_d;
  logic [MEMB_W-1:0] v_q, v_d, v_next;
  logic [TW-1:0]     tu_cnt_q, tu_cnt_d;
  logic [RW-1:0]     ref_cnt_q, ref_cnt_d;
  logic              mode_q, mode_d;
  logic              spike_q, spike_d;
  logic              start_li_q, start_li_d;
  logic              valid_q, valid_d;
  logic              win_end;
  logic signed [SW-1:0] sum;

  // Integration step with two guard bits so that underflow shows up as a
  // negative value and overflow above the unsigned range can be clamped.
  always_comb begin
    sum = $signed({2'b00, v_q})
        + (nif.spike_ip_nub ? INC_S  : ZERO_S)
        - (nif.TU_incre     ? LEAK_S : ZERO_S)
        - (nif.li           ? INH_S  : ZERO_S);
    v_next = sum[MEMB_W-1:0];
    if (sum < ZERO_S) begin
      v_next = '0;
    end else if (sum > MAX_S) begin
      v_next = '1;
    end
  end

  always_comb begin
    state_d    = state_q;
    v_d        = v_q;
    tu_cnt_d   = tu_cnt_q;
    ref_cnt_d  = ref_cnt_q;
    mode_d     = mode_q;
    spike_d    = 1'b0;
    start_li_d = 1'b0;
    valid_d    = 1'b0;

    // The window counter saturates at T_WIN; a saturated counter keeps
    // win_end high so an ARB still in progress exits to IDLE once resolved.
    if (state_q != IDLE && nif.TU_incre && tu_cnt_q != TW'(T_WIN)) begin
      tu_cnt_d = tu_cnt_q + 1'b1;
    end
    win_end = (tu_cnt_d == TW'(T_WIN));

    if (nif.isor_0_start || nif.isor_1_start) begin
      state_d   = INTEG;
      v_d       = '0;
      tu_cnt_d  = '0;
      ref_cnt_d = '0;
      mode_d    = nif.isor_1_start & ~nif.isor_0_start;
    end else begin
      case (state_q)
        INTEG: begin
          if (win_end) begin
            state_d = IDLE;
          end else if (v_q >= MEMB_W'(V_TH)) begin
            if (!mode_q) begin
              state_d    = ARB;
              start_li_d = 1'b1;
            end else begin
              spike_d = 1'b1;
              valid_d = 1'b1;
              v_d     = '0;
            end
          end else begin
            v_d = v_next;
          end
        end
        ARB: begin
          if (nif.valid_li) begin
            v_d       = '0;
            valid_d   = 1'b1;
            spike_d   = nif.won_lost;
            ref_cnt_d = '0;
            if (win_end) begin
              state_d = IDLE;
            end else if (nif.won_lost) begin
              state_d = REFRAC;
            end else begin
              state_d = INTEG;
            end
          end
        end
        REFRAC: begin
          v_d = '0;
          if (win_end) begin
            state_d = IDLE;
          end else if (nif.TU_incre) begin
            if (ref_cnt_q == RW'(REFRAC_TU - 1)) begin
              state_d   = INTEG;
              ref_cnt_d = '0;
            end else begin
              ref_cnt_d = ref_cnt_q + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      v_q        <= '0;
      tu_cnt_q   <= '0;
      ref_cnt_q  <= '0;
      mode_q     <= 1'b0;
      spike_q    <= 1'b0;
      start_li_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      v_q        <= v_d;
      tu_cnt_q   <= tu_cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      mode_q     <= mode_d;
      spike_q    <= spike_d;
      start_li_q <= start_li_d;
      valid_q    <= valid_d;
    end
  end

  assign nif.spike_op_nu = spike_q;
  assign nif.start_li    = start_li_q;
  assign nif.valid_nu    = valid_q;
  assign dbg_state       = state_q;
  assign dbg_v           = v_q;

endmodule

// File: tb/tb_output_neuron.sv
// Self-checking bench for output_neuron: a table of per-cycle vectors plus
// hand-written sequences for reset, window end and window end during ARB.
module tb_output_neuron;

  localparam logic [1:0] S_IDLE = 2'd0, S_INTEG = 2'd1, S_ARB = 2'd2, S_REF = 2'd3;

  // input bits: {isor_0_start, isor_1_start, TU_incre, li, spike, valid_li, won_lost}
  localparam logic [6:0] I_NO = 7'b0000000, I_S0 = 7'b1000000, I_S1 = 7'b0100000,
                         I_TU = 7'b0010000, I_LI = 7'b0001000, I_SP = 7'b0000100,
                         I_VL = 7'b0000010, I_WN = 7'b0000001;
  // output bits: {spike_op_nu, start_li, valid_nu}
  localparam logic [2:0] O_NO = 3'b000, O_SL = 3'b010, O_VN = 3'b001, O_WIN = 3'b101;

  typedef struct {
    logic [6:0]  ins;
    logic [1:0]  st;
    logic [15:0] v;
    logic [2:0]  o;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [1:0]  dbg_state;
  logic [15:0] dbg_v;

  output_neuron_if nif ();

  output_neuron dut (
    .clk       (clk),
    .rst       (rst),
    .nif       (nif),
    .dbg_state (dbg_state),
    .dbg_v     (dbg_v)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [20:0] exp_q[$];
  vec_t        vecs[$];

  function automatic logic [20:0] ex(input logic [1:0] st, input logic [15:0] v,
                                     input logic [2:0] o);
    return {st, v, o};
  endfunction

  function automatic logic [20:0] sample();
    return {dbg_state, dbg_v, nif.spike_op_nu, nif.start_li, nif.valid_nu};
  endfunction

  task automatic check(input string name, input logic [20:0] got, input logic [20:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got st=%0d v=%0d out=%b, expected st=%0d v=%0d out=%b",
               name, got[20:19], got[18:3], got[2:0], exp[20:19], exp[18:3], exp[2:0]);
    end
  endtask

  task automatic drive(input logic [6:0] ins);
    {nif.isor_0_start, nif.isor_1_start, nif.TU_incre, nif.li, nif.spike_ip_nub,
     nif.valid_li, nif.won_lost} = ins;
  endtask

  // Drive one cycle of inputs, queue the expected post-edge result, then pop
  // and compare once the DUT has updated.
  task automatic step(input logic [6:0] ins, input logic [1:0] st, input logic [15:0] v,
                      input logic [2:0] o, input string name);
    logic [20:0] e;
    @(negedge clk);
    drive(ins);
    exp_q.push_back(ex(st, v, o));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(name, sample(), e);
  endtask

  task automatic add(input logic [6:0] ins, input logic [1:0] st, input int v,
                     input logic [2:0] o);
    vec_t r;
    r.ins = ins;
    r.st  = st;
    r.v   = 16'(v);
    r.o   = o;
    vecs.push_back(r);
  endtask

  task automatic build_table();
    // training win
    add(I_S0, S_INTEG, 0, O_NO);
    for (int k = 1; k <= 10; k++) add(I_SP, S_INTEG, 10 * k, O_NO);
    add(I_NO, S_ARB, 100, O_SL);
    add(I_SP | I_LI, S_ARB, 100, O_NO);
    add(I_VL | I_WN, S_REF, 0, O_WIN);
    add(I_SP, S_REF, 0, O_NO);
    add(I_TU, S_REF, 0, O_NO);
    add(I_SP, S_REF, 0, O_NO);
    add(I_TU | I_SP, S_INTEG, 0, O_NO);
    add(I_SP, S_INTEG, 10, O_NO);
    // training loss, resolved in the start_li cycle
    for (int k = 2; k <= 10; k++) add(I_SP, S_INTEG, 10 * k, O_NO);
    add(I_NO, S_ARB, 100, O_SL);
    add(I_VL, S_INTEG, 0, O_VN);
    add(I_SP, S_INTEG, 10, O_NO);
    // leak / inhibition / clamp
    add(I_S0, S_INTEG, 0, O_NO);
    for (int k = 1; k <= 5; k++) add(I_SP, S_INTEG, 10 * k, O_NO);
    add(I_TU, S_INTEG, 49, O_NO);
    add(I_TU, S_INTEG, 48, O_NO);
    add(I_TU, S_INTEG, 47, O_NO);
    add(I_LI, S_INTEG, 0, O_NO);
    for (int k = 1; k <= 8; k++) add(I_SP, S_INTEG, 10 * k, O_NO);
    add(I_LI, S_INTEG, 30, O_NO);
    add(I_SP | I_TU | I_LI, S_INTEG, 0, O_NO);
    // inference
    add(I_S1, S_INTEG, 0, O_NO);
    for (int k = 1; k <= 10; k++) add(I_SP, S_INTEG, 10 * k, O_NO);
    add(I_NO, S_INTEG, 0, O_WIN);
    add(I_SP, S_INTEG, 10, O_NO);
    // both start pulses: training mode
    add(I_S0 | I_S1, S_INTEG, 0, O_NO);
    for (int k = 1; k <= 10; k++) add(I_SP, S_INTEG, 10 * k, O_NO);
    add(I_NO, S_ARB, 100, O_SL);
    add(I_NO, S_ARB, 100, O_NO);
    add(I_VL | I_WN, S_REF, 0, O_WIN);
  endtask

  initial begin
    rst = 1'b0;
    drive(I_NO);
    build_table();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", sample(), ex(S_IDLE, 0, O_NO));
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].ins, vecs[i].st, vecs[i].v, vecs[i].o, $sformatf("vec%0d", i));
    end

    // asynchronous reset in the start_li cycle of an arbitration
    step(I_S0, S_INTEG, 0, O_NO, "rst_seq_start");
    for (int k = 1; k <= 10; k++) step(I_SP, S_INTEG, 16'(10 * k), O_NO, "rst_seq_spike");
    step(I_NO, S_ARB, 100, O_SL, "rst_seq_arb");
    #1;
    rst = 1'b0;
    #1;
    check("rst_async", sample(), ex(S_IDLE, 0, O_NO));
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) step(I_SP | I_TU | I_VL | I_WN, S_IDLE, 0, O_NO, "rst_idle");

    // window end from INTEG
    step(I_S0, S_INTEG, 0, O_NO, "win_start");
    for (int k = 1; k <= 15; k++) step(I_TU, S_INTEG, 0, O_NO, "win_tu");
    step(I_TU, S_IDLE, 0, O_NO, "win_end");
    for (int k = 0; k < 12; k++) step(I_SP, S_IDLE, 0, O_NO, "win_idle_spike");

    // window end while ARB is waiting
    step(I_S0, S_INTEG, 0, O_NO, "warb_start");
    for (int k = 1; k <= 15; k++) step(I_TU, S_INTEG, 0, O_NO, "warb_tu");
    for (int k = 1; k <= 10; k++) step(I_SP, S_INTEG, 16'(10 * k), O_NO, "warb_spike");
    step(I_NO, S_ARB, 100, O_SL, "warb_arb");
    step(I_TU, S_ARB, 100, O_NO, "warb_tu16");
    step(I_NO, S_ARB, 100, O_NO, "warb_wait");
    step(I_VL | I_WN, S_IDLE, 0, O_WIN, "warb_resolve");
    step(I_SP, S_IDLE, 0, O_NO, "warb_idle");

    @(negedge clk);
    drive(I_NO);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
